dircc_avalon_st_multi_terminal: RTL

DIRCC_AVALON_ST_MULTI_TERMINAL -- requirements
Module: dircc_avalon_st_multi_terminal

---
 rtl/dircc_avalon_st_multi_terminal.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/dircc_avalon_st_multi_terminal.sv
// Avalon-ST sink that terminates multi-channel packet streams: per-channel packet counters,
// a word counter and sticky protocol error flags, readable/clearable over an Avalon-MM CSR slave.
// Optional: define DIRCC_AVALON_ST_TERMINAL_HALT_EN to hold asi_ready low while any error flag is set.
module dircc_avalon_st_multi_terminal #(
  parameter int DATA_WIDTH    = 32,
  parameter int EMPTY_WIDTH   = 2,
  parameter int CHANNELS      = 4,
  parameter int CHANNEL_WIDTH = 2,
  parameter int ADDR_WIDTH    = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DATA_WIDTH-1:0]    asi_data,
  input  logic                     asi_valid,
  output logic                     asi_ready,
  input  logic                     asi_startofpacket,
  input  logic                     asi_endofpacket,
  input  logic [EMPTY_WIDTH-1:0]   asi_empty,
  input  logic [CHANNEL_WIDTH-1:0] asi_channel,
  input  logic [ADDR_WIDTH-1:0]    avs_address,
  input  logic                     avs_read,
  input  logic                     avs_write,
  input  logic [31:0]              avs_writedata,
  output logic [31:0]              avs_readdata,
  output logic                     irq
);

  typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

  localparam logic [CHANNEL_WIDTH:0] CH_LIM  = (CHANNEL_WIDTH+1)'(CHANNELS);
  localparam logic [ADDR_WIDTH:0]    A_FLAGS = (ADDR_WIDTH+1)'(CHANNELS);
  localparam logic [ADDR_WIDTH:0]    A_WORDS = (ADDR_WIDTH+1)'(CHANNELS + 1);

  state_t              st     [CHANNELS];
  state_t              st_nxt [CHANNELS];
  logic [31:0]         pkt_cnt[CHANNELS];
  logic [CHANNELS-1:0] pkt_evt;
  logic [CHANNELS-1:0] cnt_clr;
  logic [3:0]          flags;
  logic [3:0]          flag_set;
  logic [3:0]          flags_nxt;
  logic [31:0]         words;
  logic [31:0]         rd_mux;
  logic [ADDR_WIDTH:0] addr_ext;
  logic                beat;
  logic                in_range;
  logic                word_evt;
  logic                word_clr;
  logic                flag_clr;
  logic                ready_en;
  logic                unused_ok;

  // Payload and CSR write data carry no information for this block.
  assign unused_ok = ^{asi_data, avs_writedata};

  assign beat     = asi_valid & asi_ready;
  assign in_range = {1'b0, asi_channel} < CH_LIM;
  assign word_evt = beat & in_range;
  assign addr_ext = {1'b0, avs_address};
  assign word_clr = avs_write && (addr_ext == A_WORDS);
  assign flag_clr = avs_write && (addr_ext == A_FLAGS);

  always_comb begin
    flag_set = '0;
    pkt_evt  = '0;
    for (int c = 0; c < CHANNELS; c++) st_nxt[c] = st[c];
    if (beat) begin
      if (!in_range) begin
        flag_set[3] = 1'b1;
      end else begin
        if ((asi_empty != '0) && !asi_endofpacket) flag_set[2] = 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
          if (asi_channel == CHANNEL_WIDTH'(c)) begin
            if (asi_startofpacket) begin
              // A second SOP abandons the open packet and restarts from this beat.
              if (st[c] == IN_PKT) flag_set[0] = 1'b1;
              if (asi_endofpacket) begin
                pkt_evt[c] = 1'b1;
                st_nxt[c]  = IDLE;
              end else begin
                st_nxt[c]  = IN_PKT;
              end
            end else if (st[c] == IDLE) begin
              flag_set[1] = 1'b1;
            end else if (asi_endofpacket) begin
              pkt_evt[c] = 1'b1;
              st_nxt[c]  = IDLE;
            end
          end
        end
      end
    end
  end

  always_comb begin
    cnt_clr = '0;
    rd_mux  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (addr_ext == (ADDR_WIDTH+1)'(c)) begin
        cnt_clr[c] = avs_write;
        rd_mux     = pkt_cnt[c];
      end
    end
    if (addr_ext == A_FLAGS) rd_mux = {28'd0, flags};
    if (addr_ext == A_WORDS) rd_mux = words;
  end

  // Clear is applied first so a same-cycle event survives it.
  assign flags_nxt = (flag_clr ? 4'd0 : flags) | flag_set;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        st[c]      <= IDLE;
        pkt_cnt[c] <= '0;
      end
      flags        <= '0;
      irq          <= 1'b0;
      words        <= '0;
      avs_readdata <= '0;
      ready_en     <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      for (int c = 0; c < CHANNELS; c++) begin
        st[c] <= st_nxt[c];
        if (pkt_evt[c]) begin
          if (cnt_clr[c])               pkt_cnt[c] <= 32'd1;
          else if (pkt_cnt[c] != '1)    pkt_cnt[c] <= pkt_cnt[c] + 32'd1;
        end else if (cnt_clr[c]) begin
          pkt_cnt[c] <= '0;
        end
      end
      if (word_evt) begin
        if (word_clr)            words <= 32'd1;
        else if (words != '1)    words <= words + 32'd1;
      end else if (word_clr) begin
        words <= '0;
      end
      flags <= flags_nxt;
      irq   <= |flags_nxt;
      if (avs_read) avs_readdata <= rd_mux;
    end
  end

`ifdef DIRCC_AVALON_ST_TERMINAL_HALT_EN
  assign asi_ready = ready_en & ~(|flags);
`else
  assign asi_ready = ready_en;
`endif

endmodule
